// File: rtl/ram_burst_reader_if.sv
// Burst reader bus: command/status, RAM port and output stream.
// master is the reader's view, slave is the environment's view.
interface ram_burst_reader_if #(
    parameter int CAddrLen = 13,
    parameter int CDataLen = 128,
    parameter int CLenLen  = 9
);
    logic                AStart;
    logic [CAddrLen-1:0] AStartAddr;
    logic [CLenLen-1:0]  ALen;
    logic                ABusy;
    logic                ADone;
    logic [CAddrLen-1:0] ARamAddr;
    logic                ARamRdEn;
    logic [CDataLen-1:0] ARamMiso;
    logic [CDataLen-1:0] AStrData;
    logic                AStrValid;
    logic                AStrLast;
    logic                AStrReady;

    modport master (
        input  AStart, AStartAddr, ALen, ARamMiso, AStrReady,
        output ABusy, ADone, ARamAddr, ARamRdEn,
        output AStrData, AStrValid, AStrLast
    );

    modport slave (
        output AStart, AStartAddr, ALen, ARamMiso, AStrReady,
        input  ABusy, ADone, ARamAddr, ARamRdEn,
        input  AStrData, AStrValid, AStrLast
    );
endinterface

// File: rtl/ram_burst_reader.sv
// Sequential RAM burst reader with a 2-entry output FIFO.
// Reads are issued only when a FIFO slot is guaranteed for the returning word.
module ram_burst_reader #(
    parameter int CAddrLen = 13,
    parameter int CDataLen = 128,
    parameter int CLenLen  = 9
) (
    input  logic                AClkH,
    input  logic                AResetHN,
    input  logic                AClkHEn,
    ram_burst_reader_if.master  bus
);
    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [CAddrLen-1:0] LAddrOne = 1;
    localparam logic [CLenLen-1:0]  LLenOne  = 1;
    localparam logic [CLenLen-1:0]  LLenZero = '0;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CAddrLen-1:0] r_addr;
    logic [CLenLen-1:0]  r_issue;
    logic [CLenLen-1:0]  r_out;
    logic [CDataLen-1:0] r_fifo [2];
    logic                r_wptr;
    logic                r_rptr;
    logic [1:0]          r_cnt;
    logic                r_inflight;
    logic                r_done;

    logic                w_pop;
    logic                w_push;
    logic                w_rden;
    logic                w_accept;
    logic                w_zero_len;
    logic                w_last_pop;
    logic [2:0]          w_credit;

    always_comb begin
        w_state_nxt = r_state;
        w_rden      = 1'b0;
        w_accept    = 1'b0;
        w_zero_len  = 1'b0;
        w_last_pop  = 1'b0;
        w_push      = AClkHEn & r_inflight;
        w_pop       = AClkHEn & (r_cnt != 2'd0) & bus.AStrReady;
        // Slots already committed after this cycle's pop.
        w_credit    = {1'b0, r_cnt} + {2'b00, r_inflight}
                    - {2'b00, w_pop};
        unique case (r_state)
            S_IDLE: begin
                if (AClkHEn && bus.AStart) begin
                    if (bus.ALen != LLenZero) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_zero_len  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                w_rden = AClkHEn & (r_issue != LLenZero)
                       & (w_credit < 3'd2);
                if (w_pop && r_out == LLenOne) begin
                    w_last_pop  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge AClkH or negedge AResetHN) begin
        if (!AResetHN) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_issue    <= '0;
            r_out      <= '0;
            r_fifo[0]  <= '0;
            r_fifo[1]  <= '0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_cnt      <= 2'd0;
            r_inflight <= 1'b0;
            r_done     <= 1'b0;
        end else if (AClkHEn) begin
            r_state    <= w_state_nxt;
            r_done     <= w_last_pop | w_zero_len;
            r_inflight <= w_rden;
            if (w_accept) begin
                r_addr  <= bus.AStartAddr;
                r_issue <= bus.ALen;
                r_out   <= bus.ALen;
            end else if (w_rden) begin
                r_addr  <= r_addr + LAddrOne;
                r_issue <= r_issue - LLenOne;
            end
            if (w_push) begin
                r_fifo[r_wptr] <= bus.ARamMiso;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
                r_out  <= r_out - LLenOne;
            end
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign bus.ABusy     = (r_state == S_RUN);
    assign bus.ADone     = r_done;
    assign bus.ARamAddr  = r_addr;
    assign bus.ARamRdEn  = w_rden;
    assign bus.AStrData  = r_fifo[r_rptr];
    assign bus.AStrValid = (r_cnt != 2'd0);
    assign bus.AStrLast  = bus.AStrValid & (r_out == LLenOne);
endmodule

// File: tb/tb_ram_burst_reader.sv
// Randomized bench for ram_burst_reader against a word-queue model.
// RAM contents are a pure function of address.
module tb_ram_burst_reader;
    localparam int AW = 13;
    localparam int DW = 128;
    localparam int LW = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;

    ram_burst_reader_if #(.CAddrLen(AW), .CDataLen(DW), .CLenLen(LW)) bus ();

    ram_burst_reader #(.CAddrLen(AW), .CDataLen(DW), .CLenLen(LW)) dut (
        .AClkH   (clk),
        .AResetHN(rst_n),
        .AClkHEn (en),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [159:0] got,
                       input logic [159:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] ramf(input logic [AW-1:0] a);
        logic [31:0] x;
        x = {19'h0, a} * 32'h9E3779B1 ^ 32'hA5A5_0000;
        return {x, ~x, x ^ 32'h1234_5678, {19'h0, a}};
    endfunction

    always @(posedge clk)
        if (bus.ARamRdEn) bus.ARamMiso <= ramf(bus.ARamAddr);

    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr[$];
    int ecyc = 0;
    int first_valid, first_pop, last_pop, n_reads, n_pops, done_cnt;
    int acc, stall_left, stall_reads;
    bit busy_seen, mon_off, have_prev, prev_en;
    int en_pct, rdy_pct;
    bit en_toggle;
    logic [144:0] prev_o;

    always @(posedge clk) if (en) ecyc++;

    always @(negedge clk) begin
        if (!rst_n || mon_off) begin
            have_prev = 0;
        end else begin
            if (!en) chk("rden_gated", 160'(bus.ARamRdEn), 160'(0));
            if (have_prev && !prev_en)
                chk("hold", 160'({bus.AStrValid, bus.AStrLast, bus.ABusy,
                    bus.ADone, bus.ARamAddr, bus.AStrData}), 160'(prev_o));
            if (bus.ARamRdEn) begin
                n_reads++;
                if (exp_addr.size() == 0) chk("spur_read", 1, 0);
                else chk("addr", 160'(bus.ARamAddr),
                         160'(exp_addr.pop_front()));
            end
            if (bus.AStrValid) begin
                if (first_valid < 0) first_valid = ecyc;
                if (exp_q.size() == 0) chk("spur_valid", 1, 0);
                else chk("data", 160'(bus.AStrData), 160'(exp_q[0]));
            end else begin
                chk("last_noval", 160'(bus.AStrLast), 160'(0));
            end
            if (en && bus.AStrValid && bus.AStrReady && exp_q.size() > 0) begin
                chk("last", 160'(bus.AStrLast), 160'(exp_q.size() == 1));
                void'(exp_q.pop_front());
                n_pops++;
                if (first_pop < 0) first_pop = ecyc;
                last_pop = ecyc;
            end
            if (en && bus.ADone) done_cnt++;
            if (bus.ABusy) busy_seen = 1;
            prev_o = {bus.AStrValid, bus.AStrLast, bus.ABusy,
                      bus.ADone, bus.ARamAddr, bus.AStrData};
            prev_en = en;
            have_prev = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (en_toggle) en = ~en;
        else en = ($urandom_range(99) < en_pct);
        if (stall_left > 0) begin
            bus.AStrReady = 1'b0;
            if (first_valid >= 0) begin
                stall_left--;
                if (stall_left == 0) stall_reads = n_reads;
            end
        end else begin
            bus.AStrReady = ($urandom_range(99) < rdy_pct);
        end
    endtask

    task automatic start_cmd(input logic [AW-1:0] addr, input int len);
        first_valid = -1; first_pop = -1; last_pop = -1;
        n_reads = 0; n_pops = 0; done_cnt = 0; busy_seen = 0;
        tick();
        en = 1'b1;
        bus.AStart = 1'b1;
        bus.AStartAddr = addr;
        bus.ALen = LW'(len);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(ramf(AW'(addr + AW'(i))));
            exp_addr.push_back(AW'(addr + AW'(i)));
        end
        tick();
        acc = ecyc;
        bus.AStart = 1'b0;
    endtask

    task automatic run_burst(input logic [AW-1:0] addr, input int len,
                             input bit inject, input int stall);
        bit fin;
        bit full;
        full = (en_pct == 100 && rdy_pct == 100 && stall == 0 && !en_toggle);
        stall_left = stall;
        stall_reads = -1;
        start_cmd(addr, len);
        fin = 0;
        for (int c = 0; c < 3000 && !fin; c++) begin
            tick();
            if (inject && c == 0) begin
                bus.AStart = 1'b1;
                bus.AStartAddr = ~addr;
                bus.ALen = 9'd7;
            end else begin
                bus.AStart = 1'b0;
            end
            if (done_cnt > 0) fin = 1;
        end
        if (!fin) chk("timeout", 0, 1);
        for (int c = 0; c < 4; c++) tick();
        chk("done_once", 160'(done_cnt), 160'(1));
        chk("reads", 160'(n_reads), 160'(len));
        chk("drained", 160'(exp_q.size()), 160'(0));
        chk("busy_end", 160'(bus.ABusy), 160'(0));
        chk("busy_seen", 160'(busy_seen), 160'(len != 0));
        if (len != 0) chk("latency", 160'(first_valid - acc), 160'(2));
        if (full && len != 0)
            chk("thruput", 160'(last_pop - first_pop), 160'(len - 1));
        if (stall > 0) chk("stall_reads", 160'(stall_reads), 160'(2));
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, 160'({bus.AStrValid, bus.AStrLast, bus.ABusy, bus.ADone,
            bus.ARamRdEn, bus.ARamAddr, bus.AStrData}), 160'(0));
    endtask

    initial begin
        bus.AStart = 1'b0;
        bus.AStartAddr = '0;
        bus.ALen = '0;
        bus.AStrReady = 1'b0;
        bus.ARamMiso = '0;
        en_pct = 100; rdy_pct = 100; en_toggle = 0; stall_left = 0;
        mon_off = 0;
        #12;
        chk_zero("reset_state");
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_burst(13'h0010, 4, 0, 0);
        run_burst(13'h0010, 4, 0, 5);
        run_burst(13'h1FFE, 4, 0, 0);
        run_burst(13'h0020, 0, 0, 0);
        run_burst(13'h0040, 6, 1, 0);
        en_toggle = 1;
        run_burst(13'h0100, 3, 0, 0);
        en_toggle = 0;

        start_cmd(13'h0200, 6);
        for (int c = 0; c < 100 && n_pops < 2; c++) tick();
        chk("pops_before_rst", 160'(n_pops), 160'(2));
        mon_off = 1;
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        exp_q.delete();
        exp_addr.delete();
        @(posedge clk); #1;
        chk_zero("reset_hold");
        rst_n = 1'b1;
        mon_off = 0;
        run_burst(13'h0300, 5, 0, 0);

        for (int k = 0; k < 25; k++) begin
            logic [AW-1:0] a;
            int l;
            a = ($urandom_range(3) == 0) ? AW'(13'h1FF0 + AW'($urandom_range(15)))
                                         : AW'($urandom_range(8191));
            l = $urandom_range(24);
            en_pct  = ($urandom_range(2) == 0) ? 100 : 40 + $urandom_range(50);
            rdy_pct = ($urandom_range(2) == 0) ? 100 : 20 + $urandom_range(70);
            run_burst(a, l, (l >= 2) && ($urandom_range(1) == 1), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_burst_reader.md
Name: ram_burst_reader

Overview:
- Initiator for a single-port synchronous RAM port with one-cycle read latency.
- Accepts a burst command (start address, word count), issues sequential reads to the RAM, and delivers the words on a valid/ready stream with a last flag.
- A 2-entry output FIFO with credit-based read issue absorbs stream backpressure without losing in-flight read data.
- Sits between on-chip RAM and DMA/streaming consumers.

Parameters:
- CAddrLen, 13, RAM word-address width.
- CDataLen, 128, data word width.
- CLenLen, 9, burst length field width; max burst 2**CLenLen-1 words.

Ports:
- AClkH  in  1  clock; all state on rising edge.
- AResetHN  in  1  asynchronous active-low reset.
- AClkHEn  in  1  clock enable; state advances only on edges where 1.
- AStart  in  1  burst request, sampled when AClkHEn=1.
- AStartAddr  in  CAddrLen  first word address.
- ALen  in  CLenLen  number of words.
- ABusy  out  1  burst in progress.
- ADone  out  1  one-enabled-cycle pulse at burst completion.
- ARamAddr  out  CAddrLen  RAM address.
- ARamRdEn  out  1  RAM read enable.
- ARamMiso  in  CDataLen  RAM read data, valid on the enabled cycle after ARamRdEn=1.
- AStrData  out  CDataLen  stream data (FIFO head).
- AStrValid  out  1  stream valid.
- AStrLast  out  1  marks final word of burst; qualified by AStrValid.
- AStrReady  in  1  consumer ready.

Behaviour:
- Reset values:
  - ABusy=0, ADone=0, ARamRdEn=0, ARamAddr=0, AStrValid=0, AStrLast=0, AStrData=0.
  - FIFO empty; counters 0; in-flight flag 0.
- Clock enable: with AClkHEn=0 no register changes and ARamRdEn is forced to 0. ARamAddr holds, so pending RAM data stays stable.
- Pop: an enabled cycle with AStrValid & AStrReady.
- Command acceptance:
  - In IDLE, AStart=1 with ALen>0 latches the address counter (AStartAddr), the issue counter (ALen) and the output counter (ALen), then goes to RUN with ABusy=1.
  - AStart=1 with ALen=0 gives ADone=1 on the next enabled cycle; no reads are issued and ABusy stays 0.
  - AStart is ignored while ABusy=1.
- States:
  - IDLE -> RUN on an accepted AStart.
  - RUN -> IDLE when the last word pops. The same cycle registers ADone=1, so ADone is high for the following enabled cycle and ABusy=0 from then on.
- Read issue (combinational, RUN only): ARamRdEn = AClkHEn & (issue counter != 0) & ((FIFO count + in-flight - pop) < 2).
- ARamAddr is the address counter. On issue, the address counter increments and wraps modulo 2**CAddrLen (0x1FFF -> 0x0000), and the issue counter decrements.
- In-flight flag is registered as ARamRdEn. While the flag is 1, ARamMiso is pushed into the FIFO on the next enabled edge.
- The credit rule guarantees a push never overflows the FIFO. Simultaneous push and pop keeps the count unchanged.
- Throughput: 1 word per enabled cycle with AStrReady held high. First AStrValid comes 2 enabled cycles after AStart acceptance.
- Output:
  - AStrValid = FIFO count != 0.
  - AStrData = head entry.
  - AStrLast = AStrValid & (output counter == 1).
  - The output counter decrements on each pop.
- Backpressure: with AStrReady=0, AStrData, AStrValid and AStrLast hold stable and issue stalls once credits are exhausted.
- Reset mid-burst returns everything to reset values immediately, including a non-empty FIFO; in-flight data is discarded.

Test Plan:
- Reset, RAM[0x10..0x13]=A,B,C,D, AStart addr=0x10 len=4, AStrReady=1 -> ARamRdEn high 4 consecutive cycles, addr 0x10..0x13; stream A,B,C,D on consecutive cycles starting 2 cycles after start; AStrLast only with D; ADone pulse next cycle; ABusy low after.
- Same burst, AStrReady=0 for 5 cycles after first valid -> exactly 2 reads issued then ARamRdEn=0; AStrData stays A; on release A,B,C,D delivered with no loss or duplication.
- Start addr=0x1FFE len=4 -> ARamAddr sequence 0x1FFE,0x1FFF,0x0000,0x0001; data in that order.
- ALen=0 -> no ARamRdEn; ADone=1 exactly one cycle; ABusy stays 0. AStart during RUN -> ignored, counters unchanged.
- AClkHEn toggled 1,0,1,0... during len=3 burst -> no state change on disabled cycles; ARamRdEn=0 when AClkHEn=0; words delivered correct and in order.
- Assert AResetHN=0 mid-burst after 2 words popped -> all outputs 0 immediately; a new burst afterwards delivers correctly from its own start address.
